// File: rtl/mem_arbiter.sv
// mem_arbiter: two-to-one arbiter that puts the instruction-fetch port and the
// data port onto one memory interface. It carries one transaction at a time
// and has a per-transaction watchdog that aborts a hung access and sets a
// sticky error flag.
// Build option: define MEM_ARB_RR_EN to replace the fixed data-over-fetch
// priority with round-robin arbitration.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transaction in flight; the next request is captured here
// ST_BUSY_I | fetch transaction held downstream, waiting for mem_resp
// ST_BUSY_D | data transaction held downstream, waiting for mem_resp
module mem_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_read,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic [31:0] d_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        err
);

  // TIMEOUT = 0 disables the watchdog; keep the counter at least one bit wide
  localparam int              CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   LP_TMO   = CW'(TIMEOUT);
  localparam bit              LP_WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [31:0]   r_mem_addr;
  logic          r_mem_read;
  logic          r_mem_write;
  logic [3:0]    r_mem_wmask;
  logic [31:0]   r_mem_wdata;

  logic w_d_req;
  logic w_i_req;
  logic w_pick_d;
  logic w_busy;
  logic w_expire;
  logic w_done;

  assign w_d_req = d_read | d_write;
  assign w_i_req = i_read;
  assign w_busy  = (r_state != ST_IDLE);

`ifdef MEM_ARB_RR_EN
  // 1 = data port got the most recent grant, 0 = fetch port
  logic r_last_d;

  // on a tie, the port that was not granted last time wins
  assign w_pick_d = w_d_req & (~w_i_req | ~r_last_d);
`else
  // fixed priority: data wins over fetch
  assign w_pick_d = w_d_req;
`endif

  // mem_resp arriving in the expiry cycle takes precedence over the abort
  assign w_expire = LP_WD_EN && w_busy && !mem_resp && (r_cnt == LP_TMO);
  assign w_done   = w_busy & (mem_resp | w_expire);

  // response routing to the owning port; rdata is zero unless a real response
  assign i_resp  = (r_state == ST_BUSY_I) & w_done;
  assign d_resp  = (r_state == ST_BUSY_D) & w_done;
  assign i_rdata = ((r_state == ST_BUSY_I) && mem_resp) ? mem_rdata : 32'd0;
  assign d_rdata = ((r_state == ST_BUSY_D) && mem_resp) ? mem_rdata : 32'd0;

  assign mem_addr  = r_mem_addr;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_wmask = r_mem_wmask;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;

  // arbitration FSM with registered downstream request and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_wmask <= 4'd0;
      r_mem_wdata <= 32'd0;
`ifdef MEM_ARB_RR_EN
      r_last_d    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // a stray mem_resp here is ignored
          if (w_d_req || w_i_req) begin
            r_cnt <= '0;
            if (w_pick_d) begin
              r_state     <= ST_BUSY_D;
              r_mem_addr  <= d_addr;
              // read+write together is treated as a write and flagged
              r_mem_read  <= d_read & ~d_write;
              r_mem_write <= d_write;
              r_mem_wmask <= d_wmask;
              r_mem_wdata <= d_wdata;
              if (d_read && d_write) r_err <= 1'b1;
            end else begin
              r_state     <= ST_BUSY_I;
              r_mem_addr  <= i_addr;
              r_mem_read  <= 1'b1;
              r_mem_write <= 1'b0;
              r_mem_wmask <= 4'd0;
              r_mem_wdata <= 32'd0;
            end
`ifdef MEM_ARB_RR_EN
            r_last_d <= w_pick_d;
`endif
          end
        end
        default: begin
          if (mem_resp || w_expire) begin
            r_state     <= ST_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (w_expire) r_err <= 1'b1;
          end else if (LP_WD_EN) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized requesters and memory checked every cycle against a
// transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int TB_TMO = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_addr;
  logic        i_read;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic [31:0] d_addr;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        err;

  mem_arbiter #(.TIMEOUT(TB_TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // One outstanding transaction: who owns it, what was captured, and how many
  // busy cycles have elapsed without a memory response.
  logic        m_busy   = 1'b0;
  logic        m_own_d  = 1'b0;
  logic        m_rd     = 1'b0;
  logic        m_wr     = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [3:0]  m_wmask  = '0;
  logic [31:0] m_wdata  = '0;
  int          m_age    = 0;
  logic        m_err    = 1'b0;
  logic        m_last_d = 1'b0;
  logic        m_dreq, m_ireq, m_pick_d;

  assign m_dreq = d_read || d_write;
  assign m_ireq = i_read;
`ifdef MEM_ARB_RR_EN
  assign m_pick_d = m_dreq && !(m_ireq && m_last_d);
`else
  assign m_pick_d = m_dreq;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_err <= 1'b0; m_last_d <= 1'b0; m_age <= 0;
      m_rd <= 1'b0; m_wr <= 1'b0; m_addr <= '0; m_wmask <= '0; m_wdata <= '0;
    end else if (!m_busy) begin
      if (m_dreq || m_ireq) begin
        m_busy   <= 1'b1;
        m_age    <= 0;
        m_own_d  <= m_pick_d;
        m_last_d <= m_pick_d;
        if (m_pick_d) begin
          m_addr <= d_addr; m_wmask <= d_wmask; m_wdata <= d_wdata;
          m_wr   <= d_write; m_rd <= d_read && !d_write;
          if (d_read && d_write) m_err <= 1'b1;
        end else begin
          m_addr <= i_addr; m_rd <= 1'b1; m_wr <= 1'b0;
        end
      end
    end else if (mem_resp) begin
      m_busy <= 1'b0;
    end else if (m_age >= TB_TMO) begin
      m_busy <= 1'b0;
      m_err  <= 1'b1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  logic exp_abort, exp_i_resp, exp_d_resp;
  initial begin exp_i_resp = 1'b0; exp_d_resp = 1'b0; exp_abort = 1'b0; end

  // compare DUT against the model in the middle of every cycle
  always @(negedge clk) begin
    exp_abort  = m_busy && !mem_resp && (m_age >= TB_TMO);
    exp_i_resp = m_busy && !m_own_d && (mem_resp || exp_abort);
    exp_d_resp = m_busy &&  m_own_d && (mem_resp || exp_abort);
    chk("mem_read",  {31'd0, mem_read},  {31'd0, m_busy && m_rd});
    chk("mem_write", {31'd0, mem_write}, {31'd0, m_busy && m_wr});
    chk("err",       {31'd0, err},       {31'd0, m_err});
    chk("i_resp",    {31'd0, i_resp},    {31'd0, exp_i_resp});
    chk("d_resp",    {31'd0, d_resp},    {31'd0, exp_d_resp});
    chk("i_rdata", i_rdata, (exp_i_resp && mem_resp) ? mem_rdata : 32'd0);
    chk("d_rdata", d_rdata, (exp_d_resp && mem_resp) ? mem_rdata : 32'd0);
    if (m_busy) chk("mem_addr", mem_addr, m_addr);
    if (m_busy && m_own_d) begin
      chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, m_wmask});
      chk("mem_wdata", mem_wdata, m_wdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
  endtask

  task automatic do_tie(input bit data_first);
    i_read = 1; i_addr = 32'h100;
    d_write = 1; d_read = 0; d_addr = 32'h200; d_wdata = 32'hCAFEBABE; d_wmask = 4'b1111;
    tick();
    if (data_first) begin
      chk("tie1_write", {31'd0, mem_write}, 32'd1);
      chk("tie1_addr", mem_addr, 32'h200);
      chk("tie1_wdata", mem_wdata, 32'hCAFEBABE);
    end else begin
      chk("tie1_read", {31'd0, mem_read}, 32'd1);
      chk("tie1_addr", mem_addr, 32'h100);
    end
    mem_resp = 1; mem_rdata = 32'h1234; #1;
    chk("tie1_resp_owner", {31'd0, data_first ? d_resp : i_resp}, 32'd1);
    chk("tie1_resp_other", {31'd0, data_first ? i_resp : d_resp}, 32'd0);
    tick();
    mem_resp = 0;
    if (data_first) d_write = 0; else i_read = 0;
    tick();
    chk("tie2_addr", mem_addr, data_first ? 32'h100 : 32'h200);
    chk("tie2_read", {31'd0, mem_read}, data_first ? 32'd1 : 32'd0);
    mem_resp = 1; #1;
    chk("tie2_resp", {31'd0, data_first ? i_resp : d_resp}, 32'd1);
    tick();
    idle_inputs();
    tick();
  endtask

  bit i_act, d_act;

  task automatic rand_phase(input int n);
    int mode;
    int r;
    mode = 0;
    for (int cyc = 0; cyc < n; cyc++) begin
      tick();
      if (cyc % 200 == 0) mode = $urandom_range(0, 2);
      if (i_act && exp_i_resp) i_act = 0;
      if (!i_act) begin
        if ($urandom_range(0, 2) == 0) begin i_act = 1; i_addr = $urandom; end
      end else if ($urandom_range(0, 3) == 0) i_addr = $urandom;
      i_read = i_act;
      if (d_act && exp_d_resp) d_act = 0;
      if (!d_act) begin
        d_read = 0; d_write = 0;
        if ($urandom_range(0, 2) == 0) begin
          d_act = 1; d_addr = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom);
          r = $urandom_range(0, 31);
          if (r == 0)      begin d_read = 1; d_write = 1; end
          else if (r < 16) d_read = 1;
          else             d_write = 1;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        d_addr = $urandom; d_wdata = $urandom; d_wmask = 4'($urandom);
      end
      mem_rdata = $urandom;
      case (mode)
        0:       mem_resp = ($urandom_range(0, 2) == 0);
        1:       mem_resp = ($urandom_range(0, 13) == 0);
        default: mem_resp = ($urandom_range(0, 1) == 0);
      endcase
    end
  endtask

  initial begin
    rst_n = 0; i_addr = 0; d_addr = 0; d_wmask = 0; d_wdata = 0; mem_rdata = 0;
    idle_inputs();
    i_act = 0; d_act = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1;
    tick();

    // single fetch, memory answers 3 cycles after the request goes out
    i_read = 1; i_addr = 32'h6000_0000;
    tick();
    chk("fetch_mem_read", {31'd0, mem_read}, 32'd1);
    chk("fetch_mem_addr", mem_addr, 32'h6000_0000);
    tick(); tick();
    mem_resp = 1; mem_rdata = 32'h0000_0013; #1;
    chk("fetch_i_resp", {31'd0, i_resp}, 32'd1);
    chk("fetch_i_rdata", i_rdata, 32'h13);
    chk("fetch_d_resp", {31'd0, d_resp}, 32'd0);
    tick();
    idle_inputs();
    chk("fetch_done_read", {31'd0, mem_read}, 32'd0);
    tick();

    // spurious mem_resp while idle
    mem_resp = 1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("spur_i_resp", {31'd0, i_resp}, 32'd0);
    chk("spur_d_resp", {31'd0, d_resp}, 32'd0);
    chk("spur_d_rdata", d_rdata, 32'd0);
    tick();
    mem_resp = 0;
    chk("spur_no_read", {31'd0, mem_read | mem_write}, 32'd0);
    tick();

    // first tie: last grant was fetch, so data wins in both arbitration modes
    do_tie(1'b1);

    // data write whose inputs change while it is in flight
    d_write = 1; d_addr = 32'h300; d_wdata = 32'h1111_1111; d_wmask = 4'b0011;
    tick();
    d_addr = 32'h999; d_wdata = 32'h2222_2222; d_wmask = 4'b1100;
    tick(); tick();
    chk("hold_addr", mem_addr, 32'h300);
    chk("hold_wdata", mem_wdata, 32'h1111_1111);
    chk("hold_wmask", {28'd0, mem_wmask}, 32'h3);
    mem_resp = 1; #1;
    chk("hold_d_resp", {31'd0, d_resp}, 32'd1);
    tick();
    idle_inputs();
    tick();

    // second tie: round-robin now favours fetch, fixed priority still data
`ifdef MEM_ARB_RR_EN
    do_tie(1'b0);
`else
    do_tie(1'b1);
`endif

    // watchdog: fetch that memory never answers
    i_read = 1; i_addr = 32'h400; mem_rdata = 32'h55;
    tick();
    repeat (7) tick();
    chk("wd_not_yet", {31'd0, i_resp}, 32'd0);
    tick();
    chk("wd_i_resp", {31'd0, i_resp}, 32'd1);
    chk("wd_i_rdata", i_rdata, 32'd0);
    chk("wd_err_before", {31'd0, err}, 32'd0);
    tick();
    i_read = 0;
    chk("wd_err", {31'd0, err}, 32'd1);
    chk("wd_mem_read", {31'd0, mem_read}, 32'd0);
    tick();
    chk("wd_err_sticky", {31'd0, err}, 32'd1);

    // async reset in the middle of a transaction
    i_read = 1; i_addr = 32'h480;
    tick();
    chk("rb_mem_read", {31'd0, mem_read}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rb_async_read", {31'd0, mem_read}, 32'd0);
    chk("rb_err_clear", {31'd0, err}, 32'd0);
    idle_inputs();
    tick(); tick();
    rst_n = 1;
    tick();
    d_read = 1; d_addr = 32'h500;
    tick();
    chk("ra_mem_read", {31'd0, mem_read}, 32'd1);
    chk("ra_mem_addr", mem_addr, 32'h500);
    mem_resp = 1; mem_rdata = 32'h77; #1;
    chk("ra_d_rdata", d_rdata, 32'h77);
    tick();
    idle_inputs();
    tick();

    // randomized traffic, with a reset in between to clear the sticky flag
    rand_phase(2500);
    rst_n = 0; i_act = 0; d_act = 0; idle_inputs();
    tick(); tick();
    rst_n = 1;
    rand_phase(2500);
    idle_inputs();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
